mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, meaning width of the Opcode and Funct fields.
REQ-002 SHALL have parameter STATE_WIDTH, default 4, meaning width of the state register and the State debug output.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Opcode  input  OPCODE_WIDTH  instruction[31:26], taken from the instruction register.
REQ-006 Funct  input  OPCODE_WIDTH  instruction[5:0]; passed through to the ALU decoder only, never used by this FSM.
REQ-007 Zero  input  1  ALU zero flag from the current cycle.
REQ-008 IorD  output  1  memory address mux: 0 selects PC, 1 selects ALUOut.
REQ-009 MemWrite, IRWrite, RegWrite, PCEn  output  1 each  write enables.
REQ-010 RegDst, MemtoReg, ALUSrcA  output  1 each  datapath mux selects.
REQ-011 ALUSrcB  output  2  ALU B-input select: 00 selects B, 01 selects constant 4, 10 selects SignImm, 11 selects SignImm<<2 (the shifter output).
REQ-012 ALUOp  output  2  ALU operation: 00 add, 01 sub, 10 use Funct, 11 or.
REQ-013 PCSrc  output  2  PC source: 00 selects ALUResult, 01 selects ALUOut, 10 selects the jump target.
REQ-014 State  output  STATE_WIDTH  current state code, for debug.

Function
REQ-015 SHALL be a multicycle FSM advancing exactly one state per rising clk edge, with states encoded as: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXE=9, IEXEWB=10, JUMP=11, ORIEXE=12.
REQ-016 SHALL output, in FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCEn=1; next state DECODE.
REQ-017 SHALL output, in DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, so the branch target is latched into ALUOut.
REQ-018 SHALL take the DECODE transition by Opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) or 000101 (bne) -> BRANCH; 001000 (addi) -> ADDIEXE; 001101 (ori) -> ORIEXE; 000010 (j) -> JUMP; any other opcode -> FETCH, executed as a nop with no write enable asserted.
REQ-019 SHALL output, in MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for lw, MEMWR for sw.
REQ-020 SHALL output IorD=1 in MEMRD, next state MEMWB; and MemtoReg=1, RegDst=0, RegWrite=1 in MEMWB, next state FETCH.
REQ-021 SHALL output IorD=1, MemWrite=1 in MEMWR; next state FETCH.
REQ-022 SHALL output ALUSrcA=1, ALUSrcB=00, ALUOp=10 in EXECUTE, next state ALUWB; and RegDst=1, MemtoReg=0, RegWrite=1 in ALUWB, next state FETCH.
REQ-023 SHALL output, in ADDIEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00. In ORIEXE the outputs are identical except ALUOp=11. Both go next to IEXEWB.
REQ-024 SHALL output RegDst=0, MemtoReg=0, RegWrite=1 in IEXEWB; next state FETCH.
REQ-025 SHALL output, in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, and PCEn=Zero for beq or PCEn=~Zero for bne; next state FETCH.
REQ-026 SHALL output PCSrc=10, PCEn=1 in JUMP; next state FETCH.
REQ-027 SHALL drive every output not listed for the current state to 0; outputs are combinational from State, except PCEn in BRANCH, which also depends on Zero and Opcode.
REQ-028 SHALL give these instruction latencies, counted in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, ori 4, beq/bne 3, j 3, unsupported opcode 2.
REQ-029 SHALL ignore Opcode changes in every state except DECODE and MEMADR, plus BRANCH for the PCEn polarity.

Reset
REQ-030 SHALL force the state register to FETCH asynchronously whenever reset=0, including in the middle of an instruction.
REQ-031 SHALL force PCEn, IRWrite, MemWrite and RegWrite to 0 while reset=0; all other outputs take their FETCH values.
REQ-032 SHALL, after reset deasserts, perform its first FETCH on the first rising clk edge.

Verification
REQ-033 Reset, then Opcode=100011 held -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-034 Opcode=000100: with Zero=1 in BRANCH -> PCEn=1, PCSrc=01. Opcode=000101 with Zero=1 -> PCEn=0.
REQ-035 Opcode=101011 -> State 0,1,2,5,0; MemWrite=1 only in state 5, with IorD=1.
REQ-036 Opcode=111111 -> State 0,1,0; no write enable asserted in state 1.
REQ-037 reset pulled low asynchronously during state 3 -> State=0 immediately, before any clk edge; RegWrite=0; the FSM resumes with FETCH after release.
REQ-038 Opcode=001101 -> State 0,1,12,10,0; ALUOp=11 in state 12, RegWrite=1 with RegDst=0 in state 10.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control-unit bundle between the multicycle MIPS controller and its datapath.
// Latency: none (plain signal bundle).
// Backpressure: none; the datapath follows the control word every cycle.
//
// master : controller side (reads Opcode/Funct/Zero, drives the control word and State)
// slave  : datapath side  (drives Opcode/Funct/Zero, reads the control word and State)
interface mips_multicycle_control_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
);
  logic [OPCODE_WIDTH-1:0] Opcode;   // instruction[31:26] from the IR
  logic [OPCODE_WIDTH-1:0] Funct;    // instruction[5:0], for the ALU decoder
  logic                    Zero;     // ALU zero flag, current cycle
  logic                    IorD;     // 0: PC, 1: ALUOut as memory address
  logic                    MemWrite;
  logic                    IRWrite;
  logic                    RegWrite;
  logic                    PCEn;
  logic                    RegDst;
  logic                    MemtoReg;
  logic                    ALUSrcA;
  logic [1:0]              ALUSrcB;  // 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
  logic [1:0]              ALUOp;    // 00 add, 01 sub, 10 Funct, 11 or
  logic [1:0]              PCSrc;    // 00 ALUResult, 01 ALUOut, 10 jump target
  logic [STATE_WIDTH-1:0]  State;    // debug view of the FSM state

  modport master (
    input  Opcode, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegWrite, PCEn,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegWrite, PCEn,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: one FSM step per clk, control word decoded from state.
// Latency: lw 5, sw/R-type/addi/ori 4, beq/bne/j 3, unsupported opcode 2 cycles from FETCH.
// Backpressure: none; the FSM never stalls.
//
// Ports: clk   - sole clock, rising edge
//        reset - asynchronous, active-low; holds FETCH with all write enables low
//        ctl   - master modport of mips_multicycle_control_if (opcode/zero in, control word out)
module mips_multicycle_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  ctl
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH   = STATE_WIDTH'(0),
    DECODE  = STATE_WIDTH'(1),
    MEMADR  = STATE_WIDTH'(2),
    MEMRD   = STATE_WIDTH'(3),
    MEMWB   = STATE_WIDTH'(4),
    MEMWR   = STATE_WIDTH'(5),
    EXECUTE = STATE_WIDTH'(6),
    ALUWB   = STATE_WIDTH'(7),
    BRANCH  = STATE_WIDTH'(8),
    ADDIEXE = STATE_WIDTH'(9),
    IEXEWB  = STATE_WIDTH'(10),
    JUMP    = STATE_WIDTH'(11),
    ORIEXE  = STATE_WIDTH'(12)
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = OPCODE_WIDTH'(6'b000101);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(6'b001101);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);

  state_t state;

  // Funct belongs to the ALU decoder; this FSM never looks at it.
  logic unusedFunct;
  assign unusedFunct = ^ctl.Funct;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE: begin
          case (ctl.Opcode)
            OP_LW, OP_SW:   state <= MEMADR;
            OP_RTYPE:       state <= EXECUTE;
            OP_BEQ, OP_BNE: state <= BRANCH;
            OP_ADDI:        state <= ADDIEXE;
            OP_ORI:         state <= ORIEXE;
            OP_J:           state <= JUMP;
            default:        state <= FETCH;   // unsupported opcode runs as a nop
          endcase
        end
        MEMADR:  state <= (ctl.Opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   state <= MEMWB;
        EXECUTE: state <= ALUWB;
        ADDIEXE: state <= IEXEWB;
        ORIEXE:  state <= IEXEWB;
        default: state <= FETCH;              // write-back/terminal states and unused codes
      endcase
    end
  end

  // The control word is decoded straight from the state rather than registered:
  // BRANCH needs PCEn to follow the ALU zero flag of the same cycle, and reset
  // must pull the write enables low immediately, not at the next edge.
  always_comb begin
    ctl.IorD     = 1'b0;
    ctl.MemWrite = 1'b0;
    ctl.IRWrite  = 1'b0;
    ctl.RegWrite = 1'b0;
    ctl.PCEn     = 1'b0;
    ctl.RegDst   = 1'b0;
    ctl.MemtoReg = 1'b0;
    ctl.ALUSrcA  = 1'b0;
    ctl.ALUSrcB  = 2'b00;
    ctl.ALUOp    = 2'b00;
    ctl.PCSrc    = 2'b00;
    case (state)
      FETCH: begin
        ctl.IRWrite = 1'b1;
        ctl.ALUSrcB = 2'b01;
        ctl.PCEn    = 1'b1;
      end
      DECODE:  ctl.ALUSrcB = 2'b11;           // latch the branch target in ALUOut
      MEMADR: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'b10;
      end
      MEMRD:   ctl.IorD = 1'b1;
      MEMWB: begin
        ctl.MemtoReg = 1'b1;
        ctl.RegWrite = 1'b1;
      end
      MEMWR: begin
        ctl.IorD     = 1'b1;
        ctl.MemWrite = 1'b1;
      end
      EXECUTE: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = 2'b10;
      end
      ALUWB: begin
        ctl.RegDst   = 1'b1;
        ctl.RegWrite = 1'b1;
      end
      BRANCH: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = 2'b01;
        ctl.PCSrc   = 2'b01;
        ctl.PCEn    = (ctl.Opcode == OP_BNE) ? ~ctl.Zero : ctl.Zero;
      end
      ADDIEXE: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'b10;
      end
      ORIEXE: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = 2'b10;
        ctl.ALUOp   = 2'b11;
      end
      IEXEWB:  ctl.RegWrite = 1'b1;
      JUMP: begin
        ctl.PCSrc = 2'b10;
        ctl.PCEn  = 1'b1;
      end
      default: ;
    endcase
    // Reset leaves the FETCH mux settings visible but blocks every write.
    if (!reset) begin
      ctl.PCEn     = 1'b0;
      ctl.IRWrite  = 1'b0;
      ctl.MemWrite = 1'b0;
      ctl.RegWrite = 1'b0;
    end
  end

  assign ctl.State = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-level model plus directed instruction vectors.
module tb_mips_multicycle_control;

  localparam int OW = 6;
  localparam int SW = 4;

  // IorD MemWrite IRWrite RegWrite PCEn RegDst MemtoReg ALUSrcA | ALUSrcB | ALUOp | PCSrc
  typedef struct packed {
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       PCEn;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.OPCODE_WIDTH(OW), .STATE_WIDTH(SW)) bus ();

  mips_multicycle_control #(.OPCODE_WIDTH(OW), .STATE_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  ctl_t ctlTab [0:12];
  int   pos = 0;          // cycle index within the current instruction
  bit   logEn = 1'b0;
  int   obsState [$];
  ctl_t obsCtl [$];

  // Instruction-level model: each opcode walks a fixed state path starting at FETCH.
  // Path packed as nibbles, first state in the top nibble.
  function automatic int pathLen(logic [OW-1:0] op);
    case (op)
      6'b100011:                       return 5;
      6'b101011, 6'b000000,
      6'b001000, 6'b001101:            return 4;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default:                         return 2;
    endcase
  endfunction

  function automatic logic [19:0] pathSeq(logic [OW-1:0] op);
    case (op)
      6'b100011:            return 20'h01234;
      6'b101011:            return 20'h01250;
      6'b000000:            return 20'h01670;
      6'b001000:            return 20'h019A0;
      6'b001101:            return 20'h01CA0;
      6'b000100, 6'b000101: return 20'h01800;
      6'b000010:            return 20'h01B00;
      default:              return 20'h01000;
    endcase
  endfunction

  function automatic logic [3:0] modelState();
    logic [19:0] s;
    s = pathSeq(bus.Opcode);
    return s[19 - 4*pos -: 4];
  endfunction

  function automatic ctl_t modelCtl();
    ctl_t       c;
    logic [3:0] st;
    st = modelState();
    c  = ctlTab[st];
    if (st == 4'd8) c.PCEn = (bus.Opcode == 6'b000101) ? ~bus.Zero : bus.Zero;
    if (!reset) begin
      c.PCEn = 1'b0; c.IRWrite = 1'b0; c.MemWrite = 1'b0; c.RegWrite = 1'b0;
    end
    return c;
  endfunction

  function automatic ctl_t dutCtl();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCEn, bus.RegDst,
            bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) pos <= 0;
    else        pos <= (pos + 1 >= pathLen(bus.Opcode)) ? 0 : pos + 1;
  end

  // Single compare process: every negedge, DUT state and control word vs. the model.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (bus.State !== modelState()) begin
        errors++;
        $display("FAIL state t=%0t got %0d want %0d", $time, bus.State, modelState());
      end
      checks++;
      if (dutCtl() !== modelCtl()) begin
        errors++;
        $display("FAIL ctlword t=%0t state=%0d got %h want %h", $time, bus.State, dutCtl(), modelCtl());
      end
      if (logEn) begin
        obsState.push_back(int'(bus.State));
        obsCtl.push_back(dutCtl());
      end
    end
  end

  task automatic checkLit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Run one instruction from FETCH and compare the observed path to a literal.
  task automatic runInstr(input logic [OW-1:0] op, input logic z, input string name,
                          input int len, input logic [19:0] seq);
    logic [19:0] s;
    s = seq;
    obsState.delete();
    obsCtl.delete();
    bus.Opcode = op;
    bus.Zero   = z;
    logEn      = 1'b1;
    repeat (len) @(posedge clk);
    #2;
    logEn = 1'b0;
    checkLit({name, "_len"}, obsState.size(), len);
    for (int i = 0; i < len && i < obsState.size(); i++)
      checkLit($sformatf("%s_st%0d", name, i), obsState[i], int'(s[19 - 4*i -: 4]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ctlTab[0]  = 14'b00101000_01_00_00;  // FETCH
    ctlTab[1]  = 14'b00000000_11_00_00;  // DECODE
    ctlTab[2]  = 14'b00000001_10_00_00;  // MEMADR
    ctlTab[3]  = 14'b10000000_00_00_00;  // MEMRD
    ctlTab[4]  = 14'b00010010_00_00_00;  // MEMWB
    ctlTab[5]  = 14'b11000000_00_00_00;  // MEMWR
    ctlTab[6]  = 14'b00000001_00_10_00;  // EXECUTE
    ctlTab[7]  = 14'b00010100_00_00_00;  // ALUWB
    ctlTab[8]  = 14'b00000001_00_01_01;  // BRANCH (PCEn from Zero/opcode)
    ctlTab[9]  = 14'b00000001_10_00_00;  // ADDIEXE
    ctlTab[10] = 14'b00010000_00_00_00;  // IEXEWB
    ctlTab[11] = 14'b00001000_00_00_10;  // JUMP
    ctlTab[12] = 14'b00000001_10_11_00;  // ORIEXE

    reset      = 1'b0;
    bus.Opcode = '0;
    bus.Funct  = '0;
    bus.Zero   = 1'b0;
    #1;
    checkLit("rst_state",   int'(bus.State),   0);
    checkLit("rst_pcen",    int'(bus.PCEn),    0);
    checkLit("rst_irwrite", int'(bus.IRWrite), 0);
    checkLit("rst_alusrcb", int'(bus.ALUSrcB), 1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    runInstr(6'b100011, 1'b0, "lw", 5, 20'h01234);
    checkLit("lw_wb_regwrite",  int'(obsCtl[4].RegWrite), 1);
    checkLit("lw_wb_memtoreg",  int'(obsCtl[4].MemtoReg), 1);
    checkLit("lw_rd_regwrite",  int'(obsCtl[3].RegWrite), 0);
    checkLit("lw_rd_iord",      int'(obsCtl[3].IorD),     1);

    runInstr(6'b000100, 1'b1, "beq_z1", 3, 20'h01800);
    checkLit("beq_z1_pcen",  int'(obsCtl[2].PCEn),  1);
    checkLit("beq_z1_pcsrc", int'(obsCtl[2].PCSrc), 1);
    runInstr(6'b000101, 1'b1, "bne_z1", 3, 20'h01800);
    checkLit("bne_z1_pcen",  int'(obsCtl[2].PCEn),  0);
    runInstr(6'b000100, 1'b0, "beq_z0", 3, 20'h01800);
    checkLit("beq_z0_pcen",  int'(obsCtl[2].PCEn),  0);
    runInstr(6'b000101, 1'b0, "bne_z0", 3, 20'h01800);
    checkLit("bne_z0_pcen",  int'(obsCtl[2].PCEn),  1);

    runInstr(6'b101011, 1'b0, "sw", 4, 20'h01250);
    checkLit("sw_memwrite",  int'(obsCtl[3].MemWrite), 1);
    checkLit("sw_iord",      int'(obsCtl[3].IorD),     1);
    checkLit("sw_adr_memwr", int'(obsCtl[2].MemWrite), 0);

    runInstr(6'b111111, 1'b0, "nop", 2, 20'h01000);
    checkLit("nop_dec_we", int'({obsCtl[1].PCEn, obsCtl[1].IRWrite,
                                 obsCtl[1].MemWrite, obsCtl[1].RegWrite}), 0);

    runInstr(6'b001101, 1'b0, "ori", 4, 20'h01CA0);
    checkLit("ori_aluop",   int'(obsCtl[2].ALUOp),    3);
    checkLit("ori_regwrite", int'(obsCtl[3].RegWrite), 1);
    checkLit("ori_regdst",  int'(obsCtl[3].RegDst),   0);

    runInstr(6'b000000, 1'b0, "rtype", 4, 20'h01670);
    checkLit("rtype_aluop",  int'(obsCtl[2].ALUOp),  2);
    checkLit("rtype_regdst", int'(obsCtl[3].RegDst), 1);
    runInstr(6'b001000, 1'b0, "addi", 4, 20'h019A0);
    runInstr(6'b000010, 1'b0, "j", 3, 20'h01B00);
    checkLit("j_pcsrc", int'(obsCtl[2].PCSrc), 2);
    checkLit("j_pcen",  int'(obsCtl[2].PCEn),  1);

    // Asynchronous reset in MEMRD, between clock edges.
    bus.Opcode = 6'b100011;
    bus.Zero   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkLit("mid_pre_state", int'(bus.State), 3);
    reset = 1'b0;
    #1;
    checkLit("mid_rst_state",    int'(bus.State),    0);
    checkLit("mid_rst_regwrite", int'(bus.RegWrite), 0);
    checkLit("mid_rst_iord",     int'(bus.IorD),     0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    runInstr(6'b100011, 1'b0, "lw_after_rst", 5, 20'h01234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
